// File: rtl/booth_sched_pkg.sv
// Shared types and defaults for the Booth multiplier scheduler.
// Holds the FSM state encoding, the requester count and the default
// prep/timeout cycle counts used by booth_sched and rr_arb2.
package booth_sched_pkg;

   localparam int REQ_N        = 2;
   localparam int PREP_CYC_DEF = 2;
   localparam int TIMEOUT_DEF  = 64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_PREP,
      S_RUN,
      S_CAPTURE,
      S_DRAIN
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: grant is combinational from req/last_gnt.
// Latency: grant is zero-cycle; the pointer updates on the edge after upd.
// Backpressure: none; the caller decides when a grant is taken.
// Ports: clk, clr (async, active-high), req[1:0], upd (pointer strobe),
//        upd_idx (client just served), gnt_idx (winning client).
module rr_arb2
   import booth_sched_pkg::*;
(
   input  logic             clk,
   input  logic             clr,
   input  logic [REQ_N-1:0] req,
   input  logic             upd,
   input  logic             upd_idx,
   output logic             gnt_idx
);

   logic last_gnt;

   // Pointer resets to client 1 so client 0 wins the first tie.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         last_gnt <= 1'b1;
      end else if (upd) begin
         last_gnt <= upd_idx;
      end
   end

   // On a tie the client not served last wins; a lone requester always wins.
   always_comb begin
      gnt_idx = 1'b0;
      if (req == 2'b11) begin
         gnt_idx = ~last_gnt;
      end else if (req[1]) begin
         gnt_idx = 1'b1;
      end
   end

endmodule

// File: rtl/booth_sched.sv
// Schedules two clients onto one Booth multiplier core (go/over handshake).
// Latency: ack 1 cycle after req sampled, done PREP_CYC+1+run cycles after ack.
// Backpressure: req is a level held until ack; one operation in flight at a time.
// Ports: clk, clr (async, active-high); client side req/mplier_in/mpcand_in in,
//        ack/done/err/result out; core side core_go/core_mplier/core_mpcand out,
//        core_over/core_product in.
module booth_sched
   import booth_sched_pkg::*;
#(
   parameter int W        = 8,
   parameter int PREP_CYC = PREP_CYC_DEF,
   parameter int TIMEOUT  = TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [REQ_N-1:0]   req,
   input  logic [2*W-1:0]     mplier_in,
   input  logic [2*W-1:0]     mpcand_in,
   output logic [REQ_N-1:0]   ack,
   output logic [REQ_N-1:0]   done,
   output logic [REQ_N-1:0]   err,
   output logic [2*W-1:0]     result,
   output logic               core_go,
   output logic [W-1:0]       core_mplier,
   output logic [W-1:0]       core_mpcand,
   input  logic               core_over,
   input  logic [2*W-1:0]     core_product
);

   localparam int            CW      = $clog2(TIMEOUT);
   localparam logic [CW-1:0] PREP_LD = CW'(PREP_CYC - 1);
   localparam logic [CW-1:0] T_LAST  = CW'(TIMEOUT - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          gnt_q;
   logic          tmo_q;
   logic          arb_gnt;
   logic          arb_upd;
   logic          ld_ops;
   logic          cap_ok;
   logic          cap_tmo;

   rr_arb2 u_arb (
      .clk     (clk),
      .clr     (clr),
      .req     (req),
      .upd     (arb_upd),
      .upd_idx (gnt_q),
      .gnt_idx (arb_gnt)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ld_ops    = 1'b0;
      cap_ok    = 1'b0;
      cap_tmo   = 1'b0;
      arb_upd   = 1'b0;
      core_go   = 1'b0;
      ack       = '0;
      done      = '0;
      err       = '0;
      case (state)
         S_IDLE: begin
            if (req != '0) begin
               ld_ops    = 1'b1;
               state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            ack[gnt_q] = 1'b1;
            cnt_nxt    = PREP_LD;
            state_nxt  = S_PREP;
         end
         S_PREP: begin
            // core_over is deliberately not looked at: it may still be stale
            // from the previous run while the core reloads its operands.
            if (cnt == '0) begin
               cnt_nxt   = '0;
               state_nxt = S_RUN;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         S_RUN: begin
            core_go = 1'b1;
            cnt_nxt = cnt + CW'(1);
            // A completion arriving on the last allowed cycle beats the timeout.
            if (core_over) begin
               cap_ok    = 1'b1;
               state_nxt = S_CAPTURE;
            end else if (cnt == T_LAST) begin
               cap_tmo   = 1'b1;
               state_nxt = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            done[gnt_q] = 1'b1;
            err[gnt_q]  = tmo_q;
            arb_upd     = 1'b1;
            state_nxt   = S_DRAIN;
         end
         S_DRAIN: begin
            // Wait for the core to drop over so the next run starts clean.
            if (!core_over) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt         <= '0;
         gnt_q       <= 1'b0;
         tmo_q       <= 1'b0;
         result      <= '0;
         core_mplier <= '0;
         core_mpcand <= '0;
      end else begin
         cnt <= cnt_nxt;
         if (ld_ops) begin
            gnt_q       <= arb_gnt;
            core_mplier <= arb_gnt ? mplier_in[2*W-1:W] : mplier_in[W-1:0];
            core_mpcand <= arb_gnt ? mpcand_in[2*W-1:W] : mpcand_in[W-1:0];
         end
         if (cap_ok) begin
            result <= core_product;
            tmo_q  <= 1'b0;
         end else if (cap_tmo) begin
            result <= '0;
            tmo_q  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_booth_sched.sv
module tb_booth_sched;

   localparam int W    = 8;
   localparam int PREP = 2;
   localparam int TMO  = 64;

   logic           clk = 1'b0;
   logic           clr = 1'b0;
   logic [1:0]     req = 2'b00;
   logic [2*W-1:0] mplier_in = '0;
   logic [2*W-1:0] mpcand_in = '0;
   logic [1:0]     ack, done, err;
   logic [2*W-1:0] result;
   logic           core_go;
   logic [W-1:0]   core_mplier, core_mpcand;
   logic           core_over = 1'b0;
   logic [2*W-1:0] core_product = '0;

   booth_sched #(.W(W), .PREP_CYC(PREP), .TIMEOUT(TMO)) dut (
      .clk          (clk),
      .clr          (clr),
      .req          (req),
      .mplier_in    (mplier_in),
      .mpcand_in    (mpcand_in),
      .ack          (ack),
      .done         (done),
      .err          (err),
      .result       (result),
      .core_go      (core_go),
      .core_mplier  (core_mplier),
      .core_mpcand  (core_mpcand),
      .core_over    (core_over),
      .core_product (core_product)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural core ----------------
   // over rises lat_v cycles after go rises (lat_v==0: never), stays high
   // for hold_v cycles once go falls (counting the CAPTURE cycle), and is
   // forced high between ack and go when stale_arm is set.
   int lat_v = 1, hold_v = 0;
   bit stale_arm = 1'b0;
   int gc = 0, hold_left = 0;
   bit win = 1'b0;

   function automatic logic [15:0] core_mul(input logic [7:0] a, input logic [7:0] b);
      logic signed [15:0] x, y;
      x = {{8{a[7]}}, a};
      y = {{8{b[7]}}, b};
      return x * y;
   endfunction

   always @(negedge clk) begin
      if (clr) begin
         gc = 0; core_over = 1'b0; win = 1'b0;
      end else begin
         if (ack != 2'b00) win = 1'b1;
         if (core_go) begin
            gc++;
            hold_left    = hold_v;
            win          = 1'b0;
            core_over    = (lat_v != 0) && (gc >= lat_v);
            core_product = core_mul(core_mplier, core_mpcand);
         end else begin
            gc = 0;
            if (stale_arm && win) core_over = 1'b1;
            else if (core_over && hold_left > 0) hold_left--;
            else core_over = 1'b0;
         end
      end
   end

   // ---------------- reference model / scoreboard ----------------
   typedef struct { int idx; int mode; int val; } ack_exp_t;   // mode 1: absolute cycle, 2: gap after done
   typedef struct { int idx; logic [15:0] res; bit err; int lat_eff; logic [7:0] a; logic [7:0] b; } done_exp_t;

   ack_exp_t  ack_q[$];
   done_exp_t done_q[$];
   int last_srv = 1;

   function automatic int pick(input logic [1:0] p, input int last);
      if (p == 2'b11) return 1 - last;
      return p[1] ? 1 : 0;
   endfunction

   function automatic done_exp_t mk_done(input int idx, input logic [7:0] a, input logic [7:0] b, input int lat);
      done_exp_t d;
      int ia, ib, prod;
      ia = $signed(a);
      ib = $signed(b);
      prod = ia * ib;
      d.idx = idx; d.a = a; d.b = b;
      d.err = (lat == 0);
      d.res = (lat == 0) ? 16'h0000 : prod[15:0];
      d.lat_eff = (lat == 0) ? TMO : lat;
      return d;
   endfunction

   // ---------------- monitor ----------------
   int last_ack = -1000, last_done = -1000;
   bit go_prev = 1'b0;
   ack_exp_t  mae;
   done_exp_t mde;

   always @(negedge clk) begin
      if (clr) begin
         go_prev = 1'b0;
      end else begin
         if (core_go && !go_prev) begin
            chk("go_rise_delay", cyc - last_ack, PREP + 1);
            if (done_q.size() > 0) begin
               chk("core_mplier", core_mplier, done_q[0].a);
               chk("core_mpcand", core_mpcand, done_q[0].b);
            end
         end
         go_prev = core_go;
         if (ack != 2'b00) begin
            if (ack_q.size() == 0) chk("unexpected_ack", ack, 0);
            else begin
               mae = ack_q.pop_front();
               chk("ack_idx", ack, 1 << mae.idx);
               if (mae.mode == 1) chk("ack_time", cyc, mae.val);
               if (mae.mode == 2) chk("ack_gap", cyc - last_done, mae.val);
            end
            last_ack = cyc;
         end
         if (done != 2'b00) begin
            if (done_q.size() == 0) chk("unexpected_done", done, 0);
            else begin
               mde = done_q.pop_front();
               chk("done_idx", done, 1 << mde.idx);
               chk("result", result, mde.res);
               chk("err", err, mde.err ? (1 << mde.idx) : 0);
               chk("done_latency", cyc - last_ack, PREP + 1 + mde.lat_eff);
               chk("go_in_capture", core_go, 0);
            end
            last_done = cyc;
         end else if (err != 2'b00) begin
            chk("stray_err", err, 0);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic wait_idle();
      int bound = 0;
      while ((ack_q.size() != 0 || done_q.size() != 0) && bound < 400) begin
         @(negedge clk);
         bound++;
      end
      chk("idle_wait", ack_q.size() + done_q.size(), 0);
      repeat (hold_v + 4) @(negedge clk);
   endtask

   task automatic run_round(input logic [1:0] mask, input logic [7:0] a0, input logic [7:0] b0,
                            input logic [7:0] a1, input logic [7:0] b1,
                            input int lat, input int hold, input bit stale);
      logic [1:0] pend;
      int w, bound;
      ack_exp_t e;
      wait_idle();
      lat_v = lat; hold_v = hold; stale_arm = stale;
      pend = mask;
      w = pick(pend, last_srv);
      e.idx = w; e.mode = 1; e.val = cyc + 1;
      ack_q.push_back(e);
      done_q.push_back(mk_done(w, w ? a1 : a0, w ? b1 : b0, lat));
      last_srv = w;
      pend[w] = 1'b0;
      if (pend != 2'b00) begin
         w = pick(pend, last_srv);
         e.idx = w; e.mode = 2; e.val = 2 + ((hold > 1) ? hold : 1);
         ack_q.push_back(e);
         done_q.push_back(mk_done(w, w ? a1 : a0, w ? b1 : b0, lat));
         last_srv = w;
      end
      mplier_in = {a1, a0};
      mpcand_in = {b1, b0};
      req = mask;
      bound = 0;
      while (req != 2'b00 && bound < 400) begin
         @(negedge clk);
         bound++;
         if (ack != 2'b00) begin
            req = req & ~ack;
            // Operands of an accepted client are scrambled: they must not matter any more.
            if (ack[0]) begin mplier_in[7:0]  = 8'($urandom()); mpcand_in[7:0]  = 8'($urandom()); end
            if (ack[1]) begin mplier_in[15:8] = 8'($urandom()); mpcand_in[15:8] = 8'($urandom()); end
         end
      end
      chk("req_accepted", req, 0);
      stale_arm = stale;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ack"}, ack, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_result"}, result, 0);
      chk({tag, "_core_go"}, core_go, 0);
      chk({tag, "_core_ops"}, {core_mplier, core_mpcand}, 0);
   endtask

   task automatic mid_run_reset();
      int bound;
      ack_exp_t e;
      wait_idle();
      lat_v = 0; hold_v = 0; stale_arm = 1'b0;
      e.idx = 1; e.mode = 1; e.val = cyc + 1;
      ack_q.push_back(e);
      done_q.push_back(mk_done(1, 8'h09, 8'h0B, 0));
      mplier_in = {8'h09, 8'h00};
      mpcand_in = {8'h0B, 8'h00};
      req = 2'b10;
      bound = 0;
      while (!core_go && bound < 50) begin
         @(negedge clk);
         bound++;
         if (ack != 2'b00) req = 2'b00;
      end
      chk("reached_run", core_go, 1);
      repeat (5) @(negedge clk);
      #2 clr = 1'b1;
      #1 check_reset_outputs("midrun_reset");
      req = 2'b00;
      ack_q.delete();
      done_q.delete();
      last_srv = 1;
      repeat (2) @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      #1 clr = 1'b1;
      #2 check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      clr = 1'b0;

      run_round(2'b11, 8'd3, 8'd4, 8'hFE, 8'd7, 3, 0, 1'b0);      // tie from reset, then alternation
      run_round(2'b11, 8'd21, 8'hF3, 8'd100, 8'd2, 1, 0, 1'b0);   // further tie
      run_round(2'b01, 8'd5, 8'd17, 8'd0, 8'd0, 6, 0, 1'b0);      // single request 5x17
      run_round(2'b10, 8'd0, 8'd0, 8'd44, 8'd55, 0, 0, 1'b0);     // timeout
      run_round(2'b01, 8'h80, 8'h80, 8'd0, 8'd0, TMO, 0, 1'b0);   // over on the last RUN cycle
      run_round(2'b01, 8'd12, 8'hF0, 8'd0, 8'd0, 3, 0, 1'b1);     // stale over during PREP
      run_round(2'b11, 8'd7, 8'd9, 8'd127, 8'h81, 2, 4, 1'b0);    // drain hold
      mid_run_reset();
      run_round(2'b11, 8'd6, 8'd6, 8'd8, 8'd8, 4, 0, 1'b0);       // fresh tie after reset

      for (int i = 0; i < 25; i++) begin
         logic [1:0] m;
         int l;
         m = 2'($urandom_range(1, 3));
         l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 9);
         run_round(m, 8'($urandom()), 8'($urandom()), 8'($urandom()), 8'($urandom()),
                   l, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      wait_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
